// File: rtl/id_issue_controller_pkg.sv
// Shared decode constants for the ID issue controller: RV32 opcodes, NOP word,
// per-format register-usage masks and the controller state encoding.
package id_issue_controller_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_IA = 7'b0010011;
  localparam logic [6:0] OP_IL = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_U  = 7'b0110111;
  localparam logic [6:0] OP_J  = 7'b1101111;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef struct packed {
    logic rs1;
    logic rs2;
    logic rd;
  } reg_use_t;

  localparam reg_use_t USE_NONE = 3'b000;
  localparam reg_use_t USE_R    = 3'b111;
  localparam reg_use_t USE_I    = 3'b101;
  localparam reg_use_t USE_SB   = 3'b110;
  localparam reg_use_t USE_UJ   = 3'b001;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

  function automatic reg_use_t reg_use(input logic [6:0] op);
    reg_use_t u;
    case (op)
      OP_R:         u = USE_R;
      OP_IA, OP_IL: u = USE_I;
      OP_S, OP_B:   u = USE_SB;
      OP_U, OP_J:   u = USE_UJ;
      default:      u = USE_NONE;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/id_issue_controller_imm_gen.sv
// Immediate generator: extracts and sign-extends the RV32 immediate for
// I/S/B/U/J formats; R and unknown opcodes yield zero.
module id_issue_controller_imm_gen
  import id_issue_controller_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr,
  output logic [WIDTH-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (instr[6:0])
      OP_IA, OP_IL: imm32 = {{20{instr[31]}}, instr[31:20]};
      OP_S:         imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_B:         imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_U:         imm32 = {instr[31:12], 12'b0};
      OP_J:         imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:      imm32 = '0;
    endcase
  end

  assign imm = WIDTH'($signed(imm32));

endmodule

// File: rtl/id_issue_controller.sv
// Decode-stage issue controller: IF->EX valid/ready slot with load-use bubble
// and EX flush. Define ID_PERF_COUNTERS_EN to add stall/flush counters.
module id_issue_controller
  import id_issue_controller_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [WIDTH-1:0] if_pc,
  output logic             if_ready,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [31:0]      ex_instr,
  output logic [WIDTH-1:0] ex_pc,
  output logic [WIDTH-1:0] ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  input  logic             flush
`ifdef ID_PERF_COUNTERS_EN
  ,
  output logic [31:0]      stall_count,
  output logic [31:0]      flush_count
`endif
);

  reg_use_t         use_w;
  logic [4:0]       dec_rs1, dec_rs2, dec_rd;
  logic [WIDTH-1:0] dec_imm;
  logic             dec_load;
  logic             slot_free, hazard;
  logic             load_bubble, load_dec, stall_evt;

  state_e           state_q, state_d;
  logic             ex_valid_q, ex_valid_d;
  logic [31:0]      ex_instr_q, ex_instr_d;
  logic [WIDTH-1:0] ex_pc_q, ex_pc_d;
  logic [WIDTH-1:0] ex_imm_q, ex_imm_d;
  logic [4:0]       ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
  logic             trk_vld_q, trk_vld_d;
  logic [4:0]       trk_rd_q, trk_rd_d;

  assign use_w    = reg_use(if_instr[6:0]);
  assign dec_rs1  = use_w.rs1 ? if_instr[19:15] : 5'd0;
  assign dec_rs2  = use_w.rs2 ? if_instr[24:20] : 5'd0;
  assign dec_rd   = use_w.rd  ? if_instr[11:7]  : 5'd0;
  assign dec_load = (if_instr[6:0] == OP_IL);

  id_issue_controller_imm_gen #(.WIDTH(WIDTH)) u_immediate_generator (
    .instr (if_instr),
    .imm   (dec_imm)
  );

  assign slot_free = !ex_valid_q || ex_ready;
  // Unused indices decode to 0 and the tracker never holds x0, so x0 cannot match.
  assign hazard = if_valid && trk_vld_q &&
                  ((dec_rs1 != 5'd0 && dec_rs1 == trk_rd_q) ||
                   (dec_rs2 != 5'd0 && dec_rs2 == trk_rd_q));

  always_comb begin
    if_ready    = 1'b0;
    load_bubble = 1'b0;
    load_dec    = 1'b0;
    stall_evt   = 1'b0;
    state_d     = state_q;
    if (flush) begin
      if_ready    = 1'b1;
      load_bubble = 1'b1;
      state_d     = ST_RUN;
    end else if (state_q == ST_BUBBLE) begin
      load_bubble = 1'b1;
      state_d     = ST_RUN;
    end else if (slot_free) begin
      if (hazard) begin
        load_bubble = 1'b1;
        stall_evt   = 1'b1;
        state_d     = ST_BUBBLE;
      end else begin
        if_ready = 1'b1;
        if (if_valid) load_dec = 1'b1;
        else          load_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_instr_d = ex_instr_q;
    ex_pc_d    = ex_pc_q;
    ex_imm_d   = ex_imm_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_rd_d    = ex_rd_q;
    trk_vld_d  = trk_vld_q;
    trk_rd_d   = trk_rd_q;
    if (load_bubble) begin
      ex_valid_d = 1'b0;
      ex_instr_d = NOP_INSTR;
      ex_pc_d    = '0;
      ex_imm_d   = '0;
      ex_rs1_d   = '0;
      ex_rs2_d   = '0;
      ex_rd_d    = '0;
      trk_vld_d  = 1'b0;
      trk_rd_d   = '0;
    end else if (load_dec) begin
      ex_valid_d = 1'b1;
      ex_instr_d = if_instr;
      ex_pc_d    = if_pc;
      ex_imm_d   = dec_imm;
      ex_rs1_d   = dec_rs1;
      ex_rs2_d   = dec_rs2;
      ex_rd_d    = dec_rd;
      trk_vld_d  = dec_load && (dec_rd != 5'd0);
      trk_rd_d   = dec_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      ex_valid_q <= 1'b0;
      ex_instr_q <= NOP_INSTR;
      ex_pc_q    <= '0;
      ex_imm_q   <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
      trk_vld_q  <= 1'b0;
      trk_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      ex_valid_q <= ex_valid_d;
      ex_instr_q <= ex_instr_d;
      ex_pc_q    <= ex_pc_d;
      ex_imm_q   <= ex_imm_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_rd_q    <= ex_rd_d;
      trk_vld_q  <= trk_vld_d;
      trk_rd_q   <= trk_rd_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_instr = ex_instr_q;
  assign ex_pc    = ex_pc_q;
  assign ex_imm   = ex_imm_q;
  assign ex_rs1   = ex_rs1_q;
  assign ex_rs2   = ex_rs2_q;
  assign ex_rd    = ex_rd_q;

`ifdef ID_PERF_COUNTERS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && flush_cnt_q != 32'hFFFF_FFFF)     flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  logic unused_stall_evt;
  assign unused_stall_evt = stall_evt;
`endif

endmodule
